// File: rtl/rr_arb_mux.sv
// N-channel registered data multiplexer with valid/ready handshaking.
// Selection is manual, fixed priority, or round-robin.
module rr_arb_mux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 2,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_FIXED  = 2'b01,
      MODE_RR     = 2'b10,
      MODE_RR_ALT = 2'b11
   } mode_e;

   logic              load;
   logic              gnt_any;
   logic [SEL_W-1:0]  gnt_idx;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  rr_next;
   logic [NUM_CH-1:0] grant;

   // The output register can take a new beat when empty or draining this cycle.
   assign load = !out_valid || out_ready;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (load) begin
         case (mode_e'(mode))
            MODE_MANUAL: begin
               if (int'(sel) < NUM_CH && in_valid[sel]) begin
                  gnt_any = 1'b1;
                  gnt_idx = sel;
               end
            end
            MODE_FIXED: begin
               for (int i = NUM_CH - 1; i >= 0; i--) begin
                  if (in_valid[i]) begin
                     gnt_any = 1'b1;
                     gnt_idx = SEL_W'(i);
                  end
               end
            end
            default: begin
               // Scan offsets downward so the nearest valid channel past rr_ptr wins last.
               for (int k = NUM_CH - 1; k >= 0; k--) begin
                  if (in_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
                     gnt_any = 1'b1;
                     gnt_idx = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      grant = '0;
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   assign in_ready = rst ? '0 : grant;
   assign rr_next  = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
      end else if (gnt_any) begin
         out_valid <= 1'b1;
         out_data  <= in_data[gnt_idx*DATA_W +: DATA_W];
         out_ch    <= gnt_idx;
         if (mode[1]) rr_ptr <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised and directed bench for rr_arb_mux: a reference model predicts grants
// and pushes beats to a scoreboard; a monitor pops them on each output handshake.
module tb_rr_arb_mux;

   localparam int N  = 4;
   localparam int DW = 2;
   localparam int SW = 2;

   logic            clk;
   logic            rst;
   logic [1:0]      mode;
   logic [SW-1:0]   sel;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_ch;
   logic            out_ready;

   rr_arb_mux #(.NUM_CH(N), .DATA_W(DW), .SEL_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         sb[$];
   logic [DW-1:0] dat[N];
   int            checks = 0;
   int            errors = 0;
   int            m_ptr  = 0;
   logic          m_valid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference grant: rules applied directly to the set of valid channels.
   function automatic int model_grant(input logic [1:0] md, input int s,
                                      input logic [N-1:0] v, input int ptr);
      int best;
      int best_dist;
      best = -1;
      best_dist = N;
      if (md == 2'b00) return (s < N && v[s]) ? s : -1;
      if (md == 2'b01) begin
         for (int i = 0; i < N; i++) if (v[i]) return i;
         return -1;
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && ((i - ptr + N) % N) < best_dist) begin
            best = i;
            best_dist = (i - ptr + N) % N;
         end
      end
      return best;
   endfunction

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic cycle(input logic [1:0] md, input logic [SW-1:0] s,
                        input logic [N-1:0] v, input logic rdy);
      int    g;
      int    exp_rdy;
      beat_t b;
      mode = md;
      sel = s;
      in_valid = v;
      out_ready = rdy;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = dat[i];
      @(negedge clk);
      g = (m_valid && !rdy) ? -1 : model_grant(md, int'(s), v, m_ptr);
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      check("in_ready", int'(in_ready), exp_rdy);
      check("out_valid", int'(out_valid), int'(m_valid));
      if (g >= 0) begin
         b.ch = g;
         b.data = dat[g];
         sb.push_back(b);
         if (md[1]) m_ptr = (g + 1) % N;
         m_valid = 1'b1;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between clock edges and checks that state clears at once.
   task automatic do_reset();
      in_valid = '1;
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_ch", int'(out_ch), 0);
      check("rst_in_ready", int'(in_ready), 0);
      sb.delete();
      m_valid = 1'b0;
      m_ptr = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: pops one expected beat per output handshake.
   initial begin : monitor
      beat_t         b;
      int            last_ch;
      logic [DW-1:0] last_data;
      last_ch = 0;
      last_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_ch = 0;
            last_data = '0;
         end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got ch %0d data %0d, expected no beat at %0t",
                        out_ch, out_data, $time);
            end else begin
               b = sb.pop_front();
               check("beat_ch", int'(out_ch), b.ch);
               check("beat_data", int'(out_data), int'(b.data));
               last_ch = b.ch;
               last_data = b.data;
            end
         end else if (!out_valid) begin
            check("idle_ch_hold", int'(out_ch), last_ch);
            check("idle_data_hold", int'(out_data), int'(last_data));
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1;
      mode = 2'b00;
      sel = '0;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) dat[i] = DW'(i);
      @(posedge clk);
      #1;
      do_reset();

      // Manual select: sel 3,1,0 then an invalid selected channel.
      cycle(2'b00, 2'd3, 4'b1111, 1'b1);
      cycle(2'b00, 2'd1, 4'b1111, 1'b1);
      cycle(2'b00, 2'd0, 4'b1111, 1'b1);
      cycle(2'b00, 2'd2, 4'b1011, 1'b1);
      cycle(2'b00, 2'd2, 4'b1011, 1'b1);

      // Fixed priority: ch1 always beats ch3.
      repeat (4) cycle(2'b01, 2'd0, 4'b1010, 1'b1);
      cycle(2'b01, 2'd0, 4'b0000, 1'b1);

      // Round-robin fairness from reset, then skipping from rr_ptr=2.
      do_reset();
      repeat (6) cycle(2'b10, 2'd0, 4'b1111, 1'b1);
      cycle(2'b10, 2'd0, 4'b0011, 1'b1);
      cycle(2'b10, 2'd0, 4'b0011, 1'b1);

      // Backpressure, release with same-cycle drain and refill, mode 11 as round-robin.
      cycle(2'b10, 2'd0, 4'b1111, 1'b1);
      repeat (3) cycle(2'b10, 2'd0, 4'b1111, 1'b0);
      cycle(2'b10, 2'd0, 4'b1111, 1'b1);
      cycle(2'b11, 2'd0, 4'b1111, 1'b0);

      // Asynchronous reset with a beat pending, then rotation restarts at ch0.
      do_reset();
      cycle(2'b10, 2'd0, 4'b1111, 1'b1);
      cycle(2'b10, 2'd0, 4'b1111, 1'b1);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) dat[i] = DW'($urandom_range(0, (1 << DW) - 1));
         cycle(2'($urandom_range(0, 3)), SW'($urandom_range(0, N - 1)),
               N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
      end

      repeat (2) cycle(2'b00, 2'd0, 4'b0000, 1'b1);
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel registered data multiplexer with valid/ready handshaking and three selection modes:
- manual select;
- fixed priority;
- round-robin arbitration.

It generalises the team's combinational 4:1 2-bit data mux into a clocked arbitration stage. Independent producers share one downstream consumer through it, with one registered output beat and backpressure.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (>= 2)
- DATA_W, 2, data width per channel
- SEL_W, $clog2(NUM_CH), width of channel index

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- mode  input  2  00 manual, 01 fixed priority, 10 round-robin, 11 treated as round-robin
- sel  input  SEL_W  channel index used in manual mode
- in_valid  input  NUM_CH  per-channel valid
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  output  NUM_CH  per-channel ready (combinational)
- out_valid  output  1  registered output valid
- out_data  output  DATA_W  registered output data
- out_ch  output  SEL_W  index of channel that produced out_data
- out_ready  input  1  downstream ready

## Operation
- The output register holds one beat.
- Load enable: load = !out_valid || out_ready.
- Grant is one-hot over NUM_CH and is computed combinationally only when load=1. Otherwise grant=0.
- in_ready[i] = load && grant[i] && !rst.
- At most one in_ready bit is high per cycle.
- Input transfer on channel i: in_valid[i] && in_ready[i] at a rising clk edge.
- Manual mode (00):
  - grant[sel] when in_valid[sel]=1.
  - If sel >= NUM_CH or in_valid[sel]=0, there is no grant. Other channels stall.
- Fixed priority (01): grant the lowest index i with in_valid[i]=1.
- Round-robin (10/11):
  - Search from rr_ptr upward, wrapping at NUM_CH-1 -> 0, and grant the first valid channel.
  - On a transfer from channel g, rr_ptr <= (g+1) mod NUM_CH.
- rr_ptr updates only on a round-robin transfer. It holds its value in modes 00/01 and through stalls.
- On transfer:
  - out_data <= in_data of the granted channel;
  - out_ch <= g;
  - out_valid <= 1.
- out_valid=1 && out_ready=1 with no new transfer: out_valid <= 0. out_data and out_ch hold their last values.
- Same-cycle output drain and new input transfer: the register is replaced, out_valid stays 1, and there are no bubbles.
- out_valid=1 && out_ready=0: the register holds, in_ready=0 on all channels, and the arbiter state is frozen.
- mode or sel changes take effect on the next grant evaluation. A beat already in the output register is unaffected.
- The upstream valid/data must stay stable until accepted. The block does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready=0 while rst=1.
- Reset is asynchronous. Assertion mid-transfer clears all state immediately, and the pending beat is discarded.
- Latency: input accepted at edge N -> out_valid/out_data visible after edge N.
- Throughput: one beat per cycle while out_ready=1 and some granted channel is valid.
- in_ready depends combinationally on in_valid, mode, sel, rr_ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Boundary conditions:
  - rr_ptr = NUM_CH-1 with a grant there: rr_ptr wraps to 0.
  - All in_valid=0: no grant, and rr_ptr is unchanged.

## Test plan
NUM_CH=4, DATA_W=2, in_data ch0..ch3 = 00,01,10,11.
- Reset, then manual mode:
  - mode=00, all valid, out_ready=1, sel stepping 3,1,0 (one per cycle) -> out_data 11,01,00 and out_ch 3,1,0 on consecutive cycles, one cycle after each accept.
  - sel=2 with in_valid[2]=0 -> in_ready=0000 and no output beat.
- Fixed priority: mode=01, in_valid=1010, out_ready=1 -> every cycle grants ch1 (out_data=01); ch3 never accepted.
- Round-robin fairness: mode=10, in_valid=1111 held, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0,1 with out_data 00,01,10,11,00,01; rr_ptr wraps 3->0.
- Round-robin skipping: mode=10, rr_ptr=2 after prior traffic, in_valid=0011 -> grant ch0, rr_ptr becomes 1. Next cycle grant ch1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with all valid -> in_ready=0000, out_data/out_ch stable, rr_ptr frozen. Release out_ready -> next channel in rotation accepted the same cycle, with no lost or duplicated beat.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid, out_data, out_ch and rr_ptr are 0 immediately. After deassertion, round-robin restarts at ch0.
